// File: rtl/id_operand_stage.sv
// rtl/id_operand_stage.sv - IF/ID register, instruction hold, operand bypass and load-use interlock
module id_operand_stage #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int NUM_FWD = 2,
  parameter int STALL_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [STALL_W-1:0]        stall,
  input  logic                      flush,
  output logic                      stallreq,
  input  logic                      if_valid,
  input  logic [PC_W-1:0]           if_pc,
  input  logic [31:0]               inst_rdata,
  output logic [4:0]                rf_raddr1,
  output logic [4:0]                rf_raddr2,
  input  logic [DATA_W-1:0]         rf_rdata1,
  input  logic [DATA_W-1:0]         rf_rdata2,
  input  logic                      wb_we,
  input  logic [4:0]                wb_waddr,
  input  logic [DATA_W-1:0]         wb_wdata,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*5-1:0]      fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]        fwd_is_load,
  output logic                      id_valid,
  output logic [PC_W-1:0]           id_pc,
  output logic [31:0]               id_inst,
  output logic [DATA_W-1:0]         src1_data,
  output logic [DATA_W-1:0]         src2_data,
  input  logic                      stat_clr,
  output logic [CNT_W-1:0]          stall_cnt
);

  logic              valid_q, valid_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              hold_q, hold_d;
  logic [31:0]       buf_q, buf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [4:0]        rs, rt;
  logic [5:0]        opcode;
  logic              rs_used, rt_used;
  logic              ld1, ld2;
  logic              unused_stall;

  // Only the ID-hold and EX-hold bits matter to this stage.
  assign unused_stall = ^{stall[0], stall[STALL_W-1:3]};

  // Stage register next state: flush, then bubble, then advance, else freeze.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    buf_d   = buf_q;
    if (flush || (stall[1] && !stall[2])) begin
      valid_d = 1'b0;
      pc_d    = '0;
      hold_d  = 1'b0;
    end else if (!stall[1]) begin
      valid_d = if_valid;
      pc_d    = if_pc;
      hold_d  = 1'b0;
    end else if (!hold_q) begin
      // The SRAM word is only valid for one cycle; capture it on the first frozen cycle.
      buf_d  = inst_rdata;
      hold_d = 1'b1;
    end
  end

  // Saturating interlock counter; clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (stat_clr)
      cnt_d = '0;
    else if (stallreq && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      hold_q  <= 1'b0;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign id_valid  = valid_q;
  assign id_pc     = pc_q;
  assign id_inst   = !valid_q ? 32'd0 : (hold_q ? buf_q : inst_rdata);
  assign stall_cnt = cnt_q;

  assign opcode    = id_inst[31:26];
  assign rs        = id_inst[25:21];
  assign rt        = id_inst[20:16];
  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

  // Decode which register fields the instruction actually reads.
  always_comb begin
    rs_used = !((opcode == 6'b000010) || (opcode == 6'b000011) || (opcode == 6'b001111));
    rt_used = (opcode == 6'b000000) || (opcode == 6'b000100) ||
              (opcode == 6'b000101) || (opcode[5:3] == 3'b101);
  end

  // Operand bypass: scanning sources oldest-first lets the youngest match overwrite.
  always_comb begin
    src1_data = rf_rdata1;
    src2_data = rf_rdata2;
    ld1       = 1'b0;
    ld2       = 1'b0;
    if (wb_we && (wb_waddr == rs)) src1_data = wb_wdata;
    if (wb_we && (wb_waddr == rt)) src2_data = wb_wdata;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_we[i] && (fwd_waddr[5*i +: 5] == rs)) begin
        src1_data = fwd_wdata[DATA_W*i +: DATA_W];
        ld1       = fwd_is_load[i];
      end
      if (fwd_we[i] && (fwd_waddr[5*i +: 5] == rt)) begin
        src2_data = fwd_wdata[DATA_W*i +: DATA_W];
        ld2       = fwd_is_load[i];
      end
    end
    if (rs == 5'd0) begin
      src1_data = '0;
      ld1       = 1'b0;
    end
    if (rt == 5'd0) begin
      src2_data = '0;
      ld2       = 1'b0;
    end
  end

  // Interlock when a used operand depends on a load that has not returned yet.
  assign stallreq = valid_q && ((rs_used && ld1) || (rt_used && ld2));

endmodule

// File: tb/tb_id_operand_stage.sv
// tb/tb_id_operand_stage.sv - directed self-checking bench for id_operand_stage
module tb_id_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] inst_rdata;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic [1:0]  fwd_we;
  logic [9:0]  fwd_waddr;
  logic [63:0] fwd_wdata;
  logic [1:0]  fwd_is_load;
  logic        stat_clr;

  logic        stallreq, id_valid;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] id_pc, id_inst, src1_data, src2_data;
  logic [15:0] stall_cnt;

  logic        s_stallreq, s_id_valid;
  logic [4:0]  s_raddr1, s_raddr2;
  logic [31:0] s_id_pc, s_id_inst, s_src1, s_src2;
  logic [1:0]  s_stall_cnt;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] ADDU_3_3 = 32'h00632021;
  localparam logic [31:0] ADDU_0_0 = 32'h00002021;
  localparam logic [31:0] BEQ_5_6  = 32'h10A60010;
  localparam logic [31:0] BEQ_6_5  = 32'h10C50010;
  localparam logic [31:0] LUI_5    = 32'h3CA51234;

  always #5 clk = ~clk;

  id_operand_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .stallreq(stallreq),
    .if_valid(if_valid), .if_pc(if_pc), .inst_rdata(inst_rdata),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_is_load(fwd_is_load),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .src1_data(src1_data), .src2_data(src2_data),
    .stat_clr(stat_clr), .stall_cnt(stall_cnt)
  );

  id_operand_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .stallreq(s_stallreq),
    .if_valid(if_valid), .if_pc(if_pc), .inst_rdata(inst_rdata),
    .rf_raddr1(s_raddr1), .rf_raddr2(s_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_is_load(fwd_is_load),
    .id_valid(s_id_valid), .id_pc(s_id_pc), .id_inst(s_id_inst),
    .src1_data(s_src1), .src2_data(s_src2),
    .stat_clr(stat_clr), .stall_cnt(s_stall_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; stall = '0; flush = 1'b0; if_valid = 1'b1; if_pc = 32'hBFC00000;
    inst_rdata = 32'hDEADBEEF; rf_rdata1 = 32'hAAAA; rf_rdata2 = 32'hBBBB;
    wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    fwd_we = '0; fwd_waddr = '0; fwd_wdata = '0; fwd_is_load = '0; stat_clr = 1'b0;
    #2;
    check_eq("rst_valid", id_valid, 0);
    check_eq("rst_pc", id_pc, 0);
    check_eq("rst_inst", id_inst, 0);
    check_eq("rst_stallreq", stallreq, 0);
    check_eq("rst_cnt", stall_cnt, 0);
    #1 rst = 1'b1;

    // Streaming fetch
    for (int i = 0; i < 3; i++) begin
      if_pc = 32'hBFC00000 + 32'(4 * i);
      step();
      inst_rdata = 32'h24010000 + 32'(i);
      #1;
      check_eq("stream_pc", id_pc, 32'hBFC00000 + 32'(4 * i));
      check_eq("stream_valid", id_valid, 1);
      check_eq("stream_inst", id_inst, 32'h24010000 + 32'(i));
    end

    // Freeze: first frozen cycle captures the word
    inst_rdata = 32'h2402AAAA; stall = 6'b000110; if_pc = 32'hBFC0000C;
    for (int i = 0; i < 3; i++) begin
      step();
      inst_rdata = 32'h2402BB00 + 32'(i);
      #1;
      check_eq("freeze_inst", id_inst, 32'h2402AAAA);
      check_eq("freeze_pc", id_pc, 32'hBFC00008);
    end
    stall = '0;
    step();
    inst_rdata = 32'h2403CCCC;
    #1;
    check_eq("release_pc", id_pc, 32'hBFC0000C);
    check_eq("release_inst", id_inst, 32'h2403CCCC);

    // Bubble: ID hold without EX hold
    stall = 6'b000010;
    step();
    check_eq("bubble_valid", id_valid, 0);
    check_eq("bubble_inst", id_inst, 0);
    stall = '0;
    step();

    // Forwarding priority
    inst_rdata = ADDU_3_3;
    fwd_we = 2'b11; fwd_waddr = {5'd3, 5'd3}; fwd_wdata = {32'h22, 32'h11};
    wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h33;
    #1;
    check_eq("raddr1", rf_raddr1, 3);
    check_eq("fwd_ex_src1", src1_data, 32'h11);
    check_eq("fwd_ex_src2", src2_data, 32'h11);
    fwd_we = 2'b10; #1;
    check_eq("fwd_mem_src1", src1_data, 32'h22);
    check_eq("fwd_mem_src2", src2_data, 32'h22);
    fwd_we = 2'b00; #1;
    check_eq("fwd_wb_src1", src1_data, 32'h33);
    wb_we = 1'b0; #1;
    check_eq("rf_src1", src1_data, 32'hAAAA);
    check_eq("rf_src2", src2_data, 32'hBBBB);
    inst_rdata = ADDU_0_0; fwd_we = 2'b11; fwd_waddr = '0; wb_we = 1'b1; wb_waddr = 5'd0; #1;
    check_eq("zero_src1", src1_data, 0);
    check_eq("zero_src2", src2_data, 0);
    check_eq("zero_stallreq", stallreq, 0);
    wb_we = 1'b0;

    // Load-use interlock
    inst_rdata = BEQ_5_6; fwd_we = 2'b01; fwd_waddr = {5'd0, 5'd5}; fwd_is_load = 2'b01; #1;
    check_eq("lu_beq_rs", stallreq, 1);
    inst_rdata = BEQ_6_5; #1;
    check_eq("lu_beq_rt", stallreq, 1);
    inst_rdata = LUI_5; #1;
    check_eq("lu_lui", stallreq, 0);
    inst_rdata = BEQ_5_6; fwd_we = 2'b11; fwd_waddr = {5'd5, 5'd5}; fwd_is_load = 2'b01; #1;
    check_eq("lu_young_load", stallreq, 1);
    fwd_is_load = 2'b10; #1;
    check_eq("lu_young_alu", stallreq, 0);
    fwd_is_load = 2'b01;

    // Interlock counter
    stat_clr = 1'b1;
    step();
    check_eq("cnt_clr", stall_cnt, 0);
    check_eq("cnt_clr_sat", s_stall_cnt, 0);
    stat_clr = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_eq("cnt_5", stall_cnt, 5);
    step();
    check_eq("cnt_6", stall_cnt, 6);
    check_eq("cnt_sat", s_stall_cnt, 3);
    stat_clr = 1'b1;
    step();
    check_eq("cnt_clr_stall", stall_cnt, 0);
    stat_clr = 1'b0;

    // Flush while frozen with hold set
    stall = 6'b000110;
    step();
    step();
    inst_rdata = 32'h01234567; #1;
    check_eq("hold_beq", id_inst, BEQ_5_6);
    check_eq("hold_stallreq", stallreq, 1);
    flush = 1'b1;
    step();
    check_eq("flush_valid", id_valid, 0);
    check_eq("flush_inst", id_inst, 0);
    check_eq("flush_stallreq", stallreq, 0);
    flush = 1'b0; stall = '0; inst_rdata = BEQ_5_6; if_pc = 32'h100;
    step();
    stall = 6'b000110;
    step();
    step();
    inst_rdata = 32'h0; #1;
    check_eq("pre_rst_cnt", stall_cnt, 5);
    check_eq("pre_rst_inst", id_inst, BEQ_5_6);

    // Reset mid-freeze
    rst = 1'b0; #1;
    check_eq("mrst_valid", id_valid, 0);
    check_eq("mrst_pc", id_pc, 0);
    check_eq("mrst_inst", id_inst, 0);
    check_eq("mrst_stallreq", stallreq, 0);
    check_eq("mrst_cnt", stall_cnt, 0);
    rst = 1'b1; stall = '0; if_pc = 32'h200;
    step();
    inst_rdata = ADDU_3_3; #1;
    check_eq("post_rst_inst", id_inst, ADDU_3_3);
    check_eq("post_rst_pc", id_pc, 32'h200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Parametrised IF/ID pipeline register and operand-fetch stage for the 5-stage MIPS core.
- Holds the fetched PC/valid and keeps the instruction word alive across multi-cycle ID freezes, because the inst SRAM returns data one cycle after the PC.
- Reads the external regfile and bypasses results from NUM_FWD in-flight stages plus the WB write port.
- Detects load-use hazards, raises stallreq, and keeps a saturating count of interlock cycles.

Parameters:
DATA_W, 32, register/operand width
PC_W, 32, PC width
NUM_FWD, 2, number of forwarding sources; index 0 is youngest (EX), higher index is older (MEM, ...)
STALL_W, 6, stall bus width; bit 1 = ID hold, bit 2 = EX hold
CNT_W, 16, interlock counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
stall  in  STALL_W  pipeline stall vector from the stall controller
flush  in  1  kill the instruction in ID
stallreq  out  1  load-use interlock request to the stall controller
if_valid  in  1  IF slot holds a real instruction
if_pc  in  PC_W  PC of the IF slot
inst_rdata  in  32  inst SRAM read data, valid the cycle after the PC is registered
rf_raddr1  out  5  regfile read address = inst[25:21]
rf_raddr2  out  5  regfile read address = inst[20:16]
rf_rdata1  in  DATA_W  regfile read data 1
rf_rdata2  in  DATA_W  regfile read data 2
wb_we  in  1  WB write enable
wb_waddr  in  5  WB write address
wb_wdata  in  DATA_W  WB write data
fwd_we  in  NUM_FWD  per-source write enable
fwd_waddr  in  NUM_FWD*5  per-source destination; source i occupies bits [5i+4:5i]
fwd_wdata  in  NUM_FWD*DATA_W  per-source result, sliced the same way
fwd_is_load  in  NUM_FWD  source i result not yet available (load still in flight)
id_valid  out  1  ID holds a live instruction
id_pc  out  PC_W  PC of the ID instruction
id_inst  out  32  instruction word in ID
src1_data  out  DATA_W  resolved rs operand
src2_data  out  DATA_W  resolved rt operand
stat_clr  in  1  synchronous clear of stall_cnt
stall_cnt  out  CNT_W  saturating count of cycles with stallreq=1

Behaviour:
- Reset (rst=0, asynchronous): id_valid=0, id_pc=0, inst hold flag=0, inst_buf=0, stall_cnt=0. Outputs during reset: id_inst=0, stallreq=0.
- Stage register update, priority high to low:
  - flush: valid<=0, pc<=0, hold flag cleared.
  - stall[1]=1 and stall[2]=0: bubble; valid<=0, pc<=0, hold flag cleared.
  - stall[1]=0: valid<=if_valid, pc<=if_pc, hold flag cleared.
  - otherwise (frozen): all state kept.
- Instruction hold:
  - First frozen cycle with hold flag=0: inst_buf<=inst_rdata and hold flag<=1.
  - Later frozen cycles: buffer unchanged.
  - id_inst = hold ? inst_buf : inst_rdata; forced to 0 when id_valid=0.
- Operand resolution, per operand, first match wins:
  - address 0 -> 0.
  - fwd source i, in ascending i, with fwd_we[i] and matching address -> fwd_wdata slice i.
  - wb_we with matching address -> wb_wdata.
  - otherwise -> rf_rdata. Resolution is purely combinational, zero latency.
- Operand usage:
  - rs used unless opcode is J (000010), JAL (000011) or LUI (001111).
  - rt used when opcode is 000000, BEQ (000100), BNE (000101), or a store (101xxx).
- Load-use interlock: stallreq=1 when id_valid, an operand is used, its first-matching fwd source has fwd_is_load=1, and its address is nonzero. An older non-load match does not clear a younger load match.
- Flush and stall interaction: flush in the same cycle as stallreq still kills ID. stallreq drops the cycle after the flush, since id_valid=0.
- stall_cnt:
  - +1 each cycle stallreq=1, saturating at 2^CNT_W-1; no wrap.
  - stat_clr has priority and loads 0, even when stallreq=1 in the same cycle.
- Reset asserted mid-stall: hold flag cleared immediately; no stale instruction survives.

Test Plan:
- Release reset, stream PCs 0xBFC00000/04/08 with stall=0 -> id_pc follows one cycle later; id_inst equals inst_rdata; id_valid=1.
- stall=6'b000110 for 3 cycles while inst_rdata changes each cycle -> id_inst stays at the word captured in the first frozen cycle; after release it follows inst_rdata again.
- EX fwd (i=0) writes $3=0x11, MEM (i=1) writes $3=0x22, WB writes $3=0x33; ID executes addu $4,$3,$3 -> src1=src2=0x11. Drop EX -> 0x22. Drop MEM -> 0x33. Read $0 while all sources target $0 -> 0.
- fwd_is_load[0]=1 with $5 as destination; ID holds beq $5,$6 -> stallreq=1. Same setup with ID holding lui $5 -> stallreq=0 (rs unused).
- Hold stallreq for 5 cycles -> stall_cnt=5. Pulse stat_clr during a stall -> 0. With CNT_W=2, stall 6 cycles -> 3.
- Assert flush while frozen with the hold flag set -> id_valid=0 and id_inst=0 next cycle. Assert rst mid-freeze -> all outputs 0 immediately.
